// File: rtl/oled_fb_pkg.sv
// oled_fb_pkg: shared sizes, write-FSM encoding and pixel helpers for the OLED frame-buffer source.
package oled_fb_pkg;
  localparam int IMG_COLS = 80;
  localparam int IMG_ROWS = 60;
  localparam int NB_IMG_PXLS = 13;
  localparam int X_SIZE = 128;
  localparam int Y_SIZE = 128;
  localparam int NB_PXLS = IMG_COLS * IMG_ROWS;
  localparam int LAST_ADDR = NB_PXLS - 1;
  localparam int C4_W = 4;
  localparam int RGB444_W = 3 * C4_W;
  localparam int RGB565_W = 16;
  typedef enum logic [1:0] {WAIT_SOF, CAPTURE, HOLD} wr_state_t;
  function automatic logic [RGB565_W-1:0] to565(logic [C4_W-1:0] r, logic [C4_W-1:0] g, logic [C4_W-1:0] b);
    return {r, r[3], g, g[3:2], b, b[3]};
  endfunction
  // 5/9/2 weights over 16 keep the sum within 8 bits (max 240)
  function automatic logic [C4_W-1:0] luma(logic [RGB444_W-1:0] p);
    logic [7:0] s;
    s = 8'd5 * 8'(p[11:8]) + 8'd9 * 8'(p[7:4]) + 8'd2 * 8'(p[3:0]);
    return s[7:4];
  endfunction
endpackage

// File: rtl/fb_bram.sv
// fb_bram: simple dual-port read-first RAM, one write port and one registered read port.
module fb_bram #(
  parameter int AW = 13,
  parameter int DW = 12,
  parameter int DEPTH = 4800
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/oled_fb_source.sv
// oled_fb_source: captures an 80x60 RGB444 stream into BRAM and serves scaled 128x128 RGB565 reads.
// Define OLED_FB_GRAY_EN to add the gray input selecting a luma output.
module oled_fb_source
  import oled_fb_pkg::*;
#(
  parameter int c_img_cols = IMG_COLS,
  parameter int c_img_rows = IMG_ROWS,
  parameter int c_nb_img_pxls = NB_IMG_PXLS,
  parameter int c_x_size = X_SIZE,
  parameter int c_y_size = Y_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [RGB444_W-1:0]         s_data,
  input  logic                        s_sof,
  input  logic                        freeze,
  input  logic [$clog2(c_x_size)-1:0] x,
  input  logic [$clog2(c_y_size)-1:0] y,
`ifdef OLED_FB_GRAY_EN
  input  logic                        gray,
`endif
  output logic [RGB565_W-1:0]         color,
  output logic                        frame_done,
  output logic                        frozen
);
  localparam logic [c_nb_img_pxls-1:0] LAST_A = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);
  wr_state_t state, state_nx;
  logic [c_nb_img_pxls-1:0] waddr, waddr_nx, wa, raddr, raddr_nx;
  logic acc, we, last;
  logic [6:0] sx;
  logic [5:0] sy;
  logic [RGB444_W-1:0] rdata;
  logic [RGB565_W-1:0] pix;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT_SOF;
      waddr <= '0;
      s_ready <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      waddr <= waddr_nx;
      s_ready <= 1'b1;
      frame_done <= last;
    end
  end
  always_comb begin
    state_nx = (state == WAIT_SOF) ? (we ? CAPTURE : WAIT_SOF)
             : (state == CAPTURE) ? (last ? (freeze ? HOLD : WAIT_SOF) : CAPTURE)
             : (freeze ? HOLD : WAIT_SOF);
    waddr_nx = we ? (last ? '0 : wa + c_nb_img_pxls'(1)) : waddr;
  end
  // an sof pixel always lands at address 0, even mid-capture
  always_comb begin
    acc = s_valid & s_ready;
    we = acc & ((state == CAPTURE) | ((state == WAIT_SOF) & s_sof));
    wa = s_sof ? '0 : waddr;
    last = we & ~s_sof & (waddr == LAST_A);
    frozen = state == HOLD;
  end
  always_comb begin
    sx = 7'((10'(x) * 10'd5) >> 3);
    sy = 6'((11'(y) * 11'd15) >> 5);
    raddr_nx = c_nb_img_pxls'(sy) * c_nb_img_pxls'(c_img_cols) + c_nb_img_pxls'(sx);
  end
  fb_bram #(.AW(c_nb_img_pxls), .DW(RGB444_W), .DEPTH(c_img_cols * c_img_rows)) u_bram (
    .clk(clk),
    .we(we),
    .waddr(wa),
    .wdata(s_data),
    .raddr(raddr),
    .rdata(rdata)
  );
`ifdef OLED_FB_GRAY_EN
  logic [C4_W-1:0] l4;
  always_comb begin
    l4 = luma(rdata);
    pix = gray ? to565(l4, l4, l4) : to565(rdata[11:8], rdata[7:4], rdata[3:0]);
  end
`else
  always_comb pix = to565(rdata[11:8], rdata[7:4], rdata[3:0]);
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raddr <= '0;
      color <= '0;
    end else begin
      raddr <= raddr_nx;
      color <= pix;
    end
  end
endmodule

// File: tb/tb_oled_fb_source.sv
// tb_oled_fb_source: randomized stream/read stimulus scored against a frame-level reference model.
module tb_oled_fb_source;
  logic clk = 0, rst = 1, s_valid = 0, s_sof = 0, freeze = 0, gray = 0;
  logic [11:0] s_data = 0;
  logic [6:0] x = 0, y = 0;
  logic s_ready, frame_done, frozen;
  logic [15:0] color;
  always #5 clk = ~clk;
  oled_fb_source dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .freeze(freeze), .x(x), .y(y),
`ifdef OLED_FB_GRAY_EN
    .gray(gray),
`endif
    .color(color), .frame_done(frame_done), .frozen(frozen)
  );
  typedef struct {logic [15:0] e; int due;} rd_t;
  rd_t rq[$];
  logic [1:0] fq[$];
  logic [1:0] fv;
  logic [11:0] mm [4800];
  int total = 0, bad = 0, cyc = 0, pos = 0;
  bit hold = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (fq.size() > 0) begin
      fv = fq.pop_front();
      chk("frame_done", 16'(frame_done), 16'(fv[1]));
      chk("frozen", 16'(frozen), 16'(fv[0]));
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      chk("color", color, rq[0].e);
      void'(rq.pop_front());
    end
  end
  function automatic logic [15:0] exp_col(int xx, int yy);
    int a, r, g, b, l;
    logic [11:0] p;
    a = (yy * 15 / 32) * 80 + xx * 5 / 8;
    p = mm[a];
    r = int'(p[11:8]); g = int'(p[7:4]); b = int'(p[3:0]);
    if (gray) begin
      l = (5 * r + 9 * g + 2 * b) / 16;
      r = l; g = l; b = l;
    end
    return 16'((r * 2 + r / 8) * 2048 + (g * 4 + g / 4) * 32 + (b * 2 + b / 8));
  endfunction
  task automatic cycle(input logic v, input logic sf, input logic [11:0] d);
    logic fd;
    fd = 0;
    s_valid = v; s_sof = sf; s_data = d;
    if (hold) begin
      if (!freeze) hold = 0;
    end else if (v && sf) begin
      mm[0] = d; pos = 1;
    end else if (v && pos > 0) begin
      mm[pos] = d; pos++;
      if (pos == 4800) begin fd = 1; pos = 0; hold = freeze; end
    end
    @(posedge clk);
    fq.push_back({fd, hold});
    #1;
  endtask
  task automatic pixels(input int n, input bit sof0, input int kind, input int base);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) cycle(0, 1'($urandom_range(1)), 12'($urandom));
      cycle(1, sof0 && i == 0, kind == 0 ? 12'(base + i) : kind == 2 ? 12'hFFF : 12'($urandom));
    end
  endtask
  task automatic rd(input int xx, input int yy);
    x = 7'(xx); y = 7'(yy);
    rq.push_back('{e: exp_col(xx, yy), due: cyc + 3});
    repeat (4) cycle(0, 0, 0);
  endtask
  task automatic reads(input int n);
    rd(127, 127); rd(0, 0); rd(127, 0); rd(0, 127); rd(64, 64);
    for (int i = 0; i < n; i++) rd($urandom_range(127), $urandom_range(127));
  endtask
  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_color", color, 16'h0000);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_frozen", 16'(frozen), 16'h0);
    chk("rst_s_ready", 16'(s_ready), 16'h0);
    pos = 0; hold = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    cycle(0, 0, 0); cycle(0, 0, 0);
    chk("s_ready", 16'(s_ready), 16'h1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1, 0, 12'($urandom));
    pixels(4800, 1, 0, 0);
    reads(12);
    cycle(1, 1, 12'hF00); cycle(1, 0, 12'h8A5); cycle(1, 0, 12'hFFF); cycle(1, 0, 12'h0F0);
    pixels(4796, 0, 1, 4);
    rd(0, 0); rd(2, 0); rd(4, 0); rd(5, 0);
`ifdef OLED_FB_GRAY_EN
    gray = 1;
    rd(4, 0); rd(5, 0); rd(0, 0); rd(2, 0);
    reads(4);
    gray = 0;
`endif
    pixels(1000, 1, 1, 0);
    pixels(4800, 1, 0, 100);
    reads(10);
    pixels(2400, 1, 1, 0);
    freeze = 1;
    pixels(2400, 0, 1, 2400);
    pixels(4800, 1, 2, 0);
    reads(10);
    freeze = 0;
    cycle(0, 0, 0);
    pixels(4800, 1, 1, 0);
    reads(10);
    pixels(2000, 1, 1, 0);
    do_reset();
    pixels(3000, 0, 0, 0);
    reads(10);
    pixels(4800, 1, 1, 0);
    reads(8);
    repeat (5) cycle(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
